// File: rtl/alu_cmd_seq_if.sv
// Command, ALU-side and response signals between the sequencer and its neighbours.
// The sequencer takes the slave view; the command source, response sink and ALU take the master view.
interface alu_cmd_seq_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [3:0] cmd_op_i;
  logic [1:0] cmd_dst_i;
  logic [1:0] cmd_src_a_i;
  logic [1:0] cmd_src_b_i;
  logic [3:0] cmd_imm_i;
  logic       cmd_use_imm_i;

  logic [3:0] alu_a_o;
  logic [3:0] alu_b_o;
  logic [3:0] alu_op_o;
  logic [3:0] alu_result_i;
  logic       alu_invalid_i;

  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [3:0] rsp_data_o;
  logic       rsp_err_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_dst_i, cmd_src_a_i, cmd_src_b_i, cmd_imm_i, cmd_use_imm_i,
    output cmd_ready_o,
    output alu_a_o, alu_b_o, alu_op_o,
    input  alu_result_i, alu_invalid_i,
    output rsp_valid_o, rsp_data_o, rsp_err_o,
    input  rsp_ready_i
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_dst_i, cmd_src_a_i, cmd_src_b_i, cmd_imm_i, cmd_use_imm_i,
    input  cmd_ready_o,
    input  alu_a_o, alu_b_o, alu_op_o,
    output alu_result_i, alu_invalid_i,
    input  rsp_valid_o, rsp_data_o, rsp_err_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Single-outstanding command sequencer in front of the 4-bit ALU with a 4x4 register file.
// Optional ALU_SEQ_ERR_CNT_EN adds a saturating 8-bit count of invalid ops (err_cnt_o).
module alu_cmd_seq (
  input  logic clk_i,
  input  logic rst_i,
  alu_cmd_seq_if.slave bus
`ifdef ALU_SEQ_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] imm;
    logic       use_imm;
  } cmd_t;

  state_t          state;
  logic [3:0][3:0] regs;
  logic [1:0]      dst_q;
  cmd_t            cmd;
  logic            accept;

  assign cmd    = '{op: bus.cmd_op_i, dst: bus.cmd_dst_i, src_a: bus.cmd_src_a_i,
                    src_b: bus.cmd_src_b_i, imm: bus.cmd_imm_i, use_imm: bus.cmd_use_imm_i};
  assign accept = bus.cmd_valid_i && bus.cmd_ready_o;

  // cmd_ready_o is registered, so it stays low on the first edge out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      regs            <= '0;
      dst_q           <= '0;
      bus.cmd_ready_o <= 1'b0;
      bus.alu_a_o     <= '0;
      bus.alu_b_o     <= '0;
      bus.alu_op_o    <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_data_o  <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready_o <= 1'b1;
          if (accept) begin
            bus.alu_a_o     <= regs[cmd.src_a];
            bus.alu_b_o     <= cmd.use_imm ? cmd.imm : regs[cmd.src_b];
            bus.alu_op_o    <= cmd.op;
            dst_q           <= cmd.dst;
            bus.cmd_ready_o <= 1'b0;
            state           <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable a full cycle; capture its result now.
          if (bus.alu_invalid_i) begin
            bus.rsp_data_o <= '0;
            bus.rsp_err_o  <= 1'b1;
          end else begin
            regs[dst_q]    <= bus.alu_result_i;
            bus.rsp_data_o <= bus.alu_result_i;
            bus.rsp_err_o  <= 1'b0;
          end
          bus.rsp_valid_o <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ERR_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_cnt_o <= '0;
    else if (state == EXEC && bus.alu_invalid_i && err_cnt_o != 8'hFF)
      err_cnt_o <= err_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq: behavioural ALU, reference register file and response scoreboard.
module tb_alu_cmd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_seq_if bus();
`ifdef ALU_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  alu_cmd_seq dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
`ifdef ALU_SEQ_ERR_CNT_EN
    ,
    .err_cnt_o(err_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] data;
    logic       err;
  } rsp_t;

  rsp_t       sb[$];
  logic [3:0] ref_regs[4];
  int         tests = 0;
  int         fails = 0;

  function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic       inv;
    inv = 1'b0;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a;
      4'd6:    r = b;
      4'd7:    r = 4'd0 - a;
      4'd8:    r = 4'd0 - b;
      4'd9:    r = ~a;
      4'd10:   r = ~b;
      default: begin r = 4'd0; inv = 1'b1; end
    endcase
    return {inv, r};
  endfunction

  // Behavioural ALU sitting downstream of the sequencer.
  always_comb {bus.alu_invalid_i, bus.alu_result_i} = alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sbi, input logic [3:0] imm, input logic ui);
    bus.cmd_op_i      = op;
    bus.cmd_dst_i     = dst;
    bus.cmd_src_a_i   = sa;
    bus.cmd_src_b_i   = sbi;
    bus.cmd_imm_i     = imm;
    bus.cmd_use_imm_i = ui;
    bus.cmd_valid_i   = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                      input logic [1:0] sbi, input logic [3:0] imm, input logic ui);
    int n;
    logic [3:0] a, b;
    logic [4:0] r;
    drive_cmd(op, dst, sa, sbi, imm, ui);
    n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: observed cmd_ready_o %0b expected 1", bus.cmd_ready_o);
      bus.cmd_valid_i = 1'b0;
      return;
    end
    a = ref_regs[sa];
    b = ui ? imm : ref_regs[sbi];
    r = alu_fn(op, a, b);
    sb.push_back('{data: r[4] ? 4'd0 : r[3:0], err: r[4]});
    if (!r[4]) ref_regs[dst] = r[3:0];
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    check("exec_rsp_valid", {7'd0, bus.rsp_valid_o}, 8'd0);
    check("exec_cmd_ready", {7'd0, bus.cmd_ready_o}, 8'd0);
    check("alu_a", {4'd0, bus.alu_a_o}, {4'd0, a});
    check("alu_b", {4'd0, bus.alu_b_o}, {4'd0, b});
    check("alu_op", {4'd0, bus.alu_op_o}, {4'd0, op});
    @(negedge clk);
    check("rsp_valid_latency", {7'd0, bus.rsp_valid_o}, 8'd1);
  endtask

  task automatic recv();
    int n;
    rsp_t e;
    bus.rsp_ready_i = 1'b1;
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50 || sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL rsp_timeout: observed rsp_valid_o %0b with %0d queued, expected a response",
             bus.rsp_valid_o, sb.size());
      bus.rsp_ready_i = 1'b0;
      return;
    end
    e = sb.pop_front();
    check("rsp_data", {4'd0, bus.rsp_data_o}, {4'd0, e.data});
    check("rsp_err", {7'd0, bus.rsp_err_o}, {7'd0, e.err});
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    check("ready_after_hs", {7'd0, bus.cmd_ready_o}, 8'd1);
    check("valid_after_hs", {7'd0, bus.rsp_valid_o}, 8'd0);
  endtask

  task automatic run(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                     input logic [1:0] sbi, input logic [3:0] imm, input logic ui);
    send(op, dst, sa, sbi, imm, ui);
    recv();
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    drive_cmd(4'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
    bus.cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {7'd0, bus.cmd_ready_o}, 8'd0);
    check("rst_rsp_valid", {7'd0, bus.rsp_valid_o}, 8'd0);
    check("rst_rsp_data", {4'd0, bus.rsp_data_o}, 8'd0);
    check("rst_rsp_err", {7'd0, bus.rsp_err_o}, 8'd0);
    check("rst_alu_a", {4'd0, bus.alu_a_o}, 8'd0);
    check("rst_alu_b", {4'd0, bus.alu_b_o}, 8'd0);
    check("rst_alu_op", {4'd0, bus.alu_op_o}, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_out_of_reset", {7'd0, bus.cmd_ready_o}, 8'd1);
`ifdef ALU_SEQ_ERR_CNT_EN
    check("err_cnt_reset", err_cnt, 8'd0);
`endif

    // Immediate loads and register arithmetic with write-back
    run(4'd6, 2'd0, 2'd0, 2'd0, 4'd3, 1'b1);
    run(4'd6, 2'd1, 2'd0, 2'd0, 4'd5, 1'b1);
    run(4'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0);
    run(4'd1, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0);
    run(4'd5, 2'd3, 2'd3, 2'd0, 4'd0, 1'b0);

    // Invalid op leaves R2 untouched
    run(4'hB, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0);
`ifdef ALU_SEQ_ERR_CNT_EN
    check("err_cnt_step", err_cnt, 8'd1);
`endif
    run(4'd5, 2'd2, 2'd2, 2'd0, 4'd0, 1'b0);

    // Modulo-16 wrap-around
    run(4'd6, 2'd0, 2'd0, 2'd0, 4'hF, 1'b1);
    run(4'd0, 2'd1, 2'd0, 2'd0, 4'd1, 1'b1);
    run(4'd8, 2'd2, 2'd0, 2'd0, 4'd0, 1'b1);
    run(4'd6, 2'd3, 2'd0, 2'd0, 4'd1, 1'b1);
    run(4'd7, 2'd3, 2'd3, 2'd0, 4'd0, 1'b0);

    // Remaining opcodes over varied register contents
    run(4'd6, 2'd1, 2'd0, 2'd0, 4'hA, 1'b1);
    run(4'd6, 2'd2, 2'd0, 2'd0, 4'h6, 1'b1);
    for (int op = 2; op <= 15; op++)
      run(op[3:0], 2'd0, 2'd1, 2'd2, 4'h9, op[0]);

    // Back-pressure: a pending command must not be taken while RESP stalls
    send(4'd0, 2'd1, 2'd3, 2'd3, 4'd0, 1'b0);
    drive_cmd(4'd5, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {7'd0, bus.rsp_valid_o}, 8'd1);
      check("bp_rsp_data", {4'd0, bus.rsp_data_o}, {4'd0, sb[0].data});
      check("bp_cmd_ready", {7'd0, bus.cmd_ready_o}, 8'd0);
      check("bp_no_accept", {4'd0, bus.alu_op_o}, 8'd0);
    end
    recv();
    run(4'd5, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0);

`ifdef ALU_SEQ_ERR_CNT_EN
    for (int i = 0; i < 300; i++) run(4'hC, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
    check("err_cnt_saturate", err_cnt, 8'd255);
`endif

    // Reset during EXEC discards the command
    drive_cmd(4'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0);
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_exec_rsp_valid", {7'd0, bus.rsp_valid_o}, 8'd0);
    check("rst_exec_cmd_ready", {7'd0, bus.cmd_ready_o}, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("rst_exec_ready_after", {7'd0, bus.cmd_ready_o}, 8'd1);
    check("rst_exec_no_rsp", {7'd0, bus.rsp_valid_o}, 8'd0);
`ifdef ALU_SEQ_ERR_CNT_EN
    check("err_cnt_cleared", err_cnt, 8'd0);
`endif
    for (int i = 0; i < 4; i++) run(4'd5, i[1:0], i[1:0], 2'd0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that sits directly upstream of the 4-bit ALU. It accepts ALU commands over a valid/ready handshake, reads operands from a 4-entry × 4-bit register file (or an immediate), and drives the ALU's A, B and op inputs from registers. It samples the ALU's result and invalid flag, writes the result back to the register file, and returns a response over a second valid/ready handshake.

## Interface
- No parameters; widths are fixed: data 4 bits, op 4 bits, 4 registers.
- clk_i  input  1  single clock, all state on rising edge
- rst_i  input  1  reset, synchronous, active-high
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  sequencer can accept a command
- cmd_op_i  input  4  ALU opcode, forwarded unchanged
- cmd_dst_i  input  2  destination register index
- cmd_src_a_i  input  2  register index for A
- cmd_src_b_i  input  2  register index for B
- cmd_imm_i  input  4  immediate value
- cmd_use_imm_i  input  1  1: B = cmd_imm_i; 0: B = reg[cmd_src_b_i]
- alu_a_o  output  4  registered A to the ALU
- alu_b_o  output  4  registered B to the ALU
- alu_op_o  output  4  registered op to the ALU
- alu_result_i  input  4  combinational ALU result
- alu_invalid_i  input  1  ALU invalid-op flag
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  downstream accepts the response
- rsp_data_o  output  4  result written to the destination register (0 if invalid)
- rsp_err_o  output  1  op was invalid, no write-back

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: cmd_ready_o=1.
  - On cmd_valid_i && cmd_ready_o, at the same edge: alu_a_o ← reg[cmd_src_a_i]; alu_b_o ← imm or reg[cmd_src_b_i]; alu_op_o ← cmd_op_i; dst latched; go to EXEC.
  - Operand reads use the register contents current at that edge.
- EXEC: cmd_ready_o=0. The ALU inputs are stable for a full cycle.
  - At the end of the cycle, alu_result_i and alu_invalid_i are sampled.
  - If the op is valid: reg[dst] ← result, rsp_data_o ← result, rsp_err_o ← 0.
  - If the op is invalid: no register write, rsp_data_o ← 0, rsp_err_o ← 1.
  - Go to RESP.
- RESP: rsp_valid_o=1, and rsp_data_o/rsp_err_o are held stable.
  - On rsp_ready_i, go to IDLE.
  - Deasserting rsp_ready_i stalls indefinitely; no command is accepted while stalled.
- The ALU contract the sequencer relies on (all arithmetic is 4-bit modulo 16):
  - 0 A+B, 1 A−B, 2 A&B, 3 A|B, 4 A^B
  - 5 A, 6 B, 7 −A, 8 −B, 9 ~A, A ~B
  - B–F: invalid, result 0.
- The sequencer does not decode opcodes; validity comes only from alu_invalid_i.
- Loading a register uses op 6 with cmd_use_imm_i=1.
- Reset values:
  - all four registers 0
  - alu_a_o/alu_b_o/alu_op_o 0
  - rsp_valid_o 0, rsp_data_o 0, rsp_err_o 0
  - cmd_ready_o 0 while rst_i is high

## Timing
- Accept edge T0. EXEC occupies cycle T0→T1. Write-back and response capture happen at edge T1. rsp_valid_o is high from T1.
- Minimum latency is 1 cycle from accept to rsp_valid_o.
- Best-case throughput is one command every 3 cycles (accept, EXEC, RESP handshake). cmd_ready_o returns 1 in the cycle after the RESP handshake edge.
- A write at T1 is visible to the next accepted command's operand reads. There are no hazards, since only one command is in flight.
- Reset in any state: the next state is IDLE and the in-flight command is discarded. No write-back occurs and no response is produced. Reset has priority over all handshakes.
- cmd_valid_i is ignored outside IDLE. rsp_valid_o never drops without a rsp_ready_i handshake, except on reset.

## Configuration
- ALU_SEQ_ERR_CNT_EN defined:
  - Adds output err_cnt_o (8 bits).
  - Increments at each EXEC→RESP edge where alu_invalid_i=1.
  - Saturates at 255 and resets to 0.
- ALU_SEQ_ERR_CNT_EN undefined: the port and its counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, then op6 imm=3 dst=0, then op6 imm=5 dst=1 → responses 3 and 5, rsp_err_o=0; rsp_valid_o rises 1 cycle after each accept.
- With R0=3, R1=5: op0 dst=2 → 8; op1 dst=3 → 4'hE; then op5 src_a=3 → 4'hE (write-back confirmed).
- Wrap-around: R0=4'hF, op0 A=R0 imm=1 → 0; op8 imm=0 → 0; op7 with A=1 → 4'hF.
- Invalid: op 4'hB dst=2 → rsp_err_o=1, rsp_data_o=0; a follow-up op5 src_a=2 returns the prior value 8. With ALU_SEQ_ERR_CNT_EN, err_cnt_o steps 0→1; after 300 invalid ops it reads 255.
- Back-pressure: hold rsp_ready_i=0 for 5 cycles in RESP with cmd_valid_i=1 → rsp_valid_o and rsp_data_o stable, cmd_ready_o=0, no second accept; release → handshake, then accept the next cycle.
- Reset during EXEC of op0 dst=2 → no response; all registers read back 0 via op5; cmd_ready_o=1 the cycle after rst_i deasserts.
